// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo round-robin read scheduler.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_SERVE = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // Index increment with wrap at n; n need not be a power of two.
    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 32'd0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] scan;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        scan   = start;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[scan]) begin
                any    = 1'b1;
                winner = scan;
            end
            scan = IDX_W'(mod_inc(32'(scan), NUM_REQ));
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin read scheduler sharing one registered valid/ready consumer between NUM_REQ fifos.
// Define FIFO_RR_ARBITER_STATS_EN to add saturating per-fifo pop counters on grant_cnt.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_empty,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_rd_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
`ifdef FIFO_RR_ARBITER_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0]  grant_cnt,
`endif
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;

    logic             can_pop;
    logic             pop;
    logic             rot_due;
    logic [IDX_W-1:0] pop_idx;
    logic [WIDTH-1:0] pop_data;
    logic [IDX_W-1:0] rot_start;
    logic             idle_any, rot_any;
    logic [IDX_W-1:0] idle_win, rot_win;

    assign can_pop   = !out_valid_q || out_ready;
    assign rot_start = IDX_W'(mod_inc(32'(cur_q), NUM_REQ));

    rr_pick #(.NUM_REQ(NUM_REQ)) u_idle_pick (
        .req    (~req_empty),
        .start  (ptr_q),
        .any    (idle_any),
        .winner (idle_win)
    );

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rot_pick (
        .req    (~req_empty),
        .start  (rot_start),
        .any    (rot_any),
        .winner (rot_win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        burst_d = burst_q;
        pop     = 1'b0;
        pop_idx = cur_q;
        rot_due = (burst_q == BURST_MAX) || req_empty[cur_q];
        case (state_q)
            ARB_IDLE: begin
                if (idle_any && can_pop) begin
                    pop     = 1'b1;
                    pop_idx = idle_win;
                    cur_d   = idle_win;
                    burst_d = CNT_W'(1);
                    state_d = ARB_SERVE;
                end
            end
            ARB_SERVE: begin
                if (!rot_due) begin
                    if (can_pop) begin
                        pop     = 1'b1;
                        burst_d = burst_q + CNT_W'(1);
                    end
                end else begin
                    // Rotation searches from cur+1 this cycle so a ready winner costs no bubble.
                    ptr_d = rot_start;
                    if (rot_any && can_pop) begin
                        pop     = 1'b1;
                        pop_idx = rot_win;
                        cur_d   = rot_win;
                        burst_d = CNT_W'(1);
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        pop_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pop_idx == IDX_W'(i)) pop_data = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = pop || (out_valid_q && !out_ready);
        out_data_d  = pop ? pop_data : out_data_q;
        out_src_d   = pop ? pop_idx  : out_src_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            cur_q       <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign req_rd_en = (pop && rst_n) ? (NUM_REQ'(1) << pop_idx) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q != ARB_IDLE) || out_valid_q;

`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];
    logic [STAT_W-1:0] stat_d [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (pop && pop_idx == IDX_W'(i) && stat_q[i] != '1) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= stat_d[i];
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*STAT_W +: STAT_W] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: behavioural fifos, table of fill patterns with
// hand-written expected source orders, plus back-pressure, mid-burst reset and stats sequences.
module tb_fifo_rr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_empty;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_rd_en;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    out_data;
    logic [1:0]      out_src;
    logic            busy;
`ifdef FIFO_RR_ARBITER_STATS_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    fifo_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_empty (req_empty),
        .req_data  (req_data),
        .req_rd_en (req_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
`ifdef FIFO_RR_ARBITER_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural fifos: combinational head data, pop on rd_en at posedge.
    logic [W-1:0] mem [NR][64];
    int head [NR] = '{default: 0};
    int tail [NR] = '{default: 0};
    int seq  [NR] = '{default: 0};

    always_comb begin
        req_empty = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            req_empty[i]       = (head[i] == tail[i]);
            req_data[i*W +: W] = mem[i][6'(head[i])];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (req_rd_en[i] && head[i] != tail[i]) head[i] <= head[i] + 1;
        end
    end

    int viol = 0;
    always @(negedge clk) begin
        #2;
        if (((req_rd_en & req_empty) != '0) || !$onehot0(req_rd_en)) viol = viol + 1;
    end

    int tests = 0;
    int fails = 0;
    logic [1:0]   exp_src_q [$];
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load(input int f, input int n);
        for (int k = 0; k < n; k++) begin
            mem[f][6'(tail[f])] = W'(f * 64 + seq[f]);
            tail[f]++;
            seq[f]++;
        end
    endtask

    task automatic expect_seq(input string s);
        int k [NR];
        for (int f = 0; f < NR; f++) k[f] = 0;
        for (int j = 0; j < s.len(); j++) begin
            int src;
            src = int'(s.getc(j)) - 48;
            exp_src_q.push_back(2'(src));
            exp_q.push_back(W'(src * 64 + k[src]));
            k[src]++;
        end
    endtask

    task automatic reset_and_load(input string name, input int cnt [NR]);
        @(negedge clk);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int f = 0; f < NR; f++) begin
            tail[f] = head[f];
            seq[f]  = 0;
        end
        for (int f = 0; f < NR; f++) load(f, cnt[f]);
        #1;
        check({name, "/rst_rd_en"},     32'(req_rd_en), 32'd0);
        check({name, "/rst_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "/rst_out_data"},  32'(out_data),  32'd0);
        check({name, "/rst_out_src"},   32'(out_src),   32'd0);
        check({name, "/rst_busy"},      32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drain(input string name, input int stall_at, input int stall_n);
        int n;
        int got;
        int cyc;
        int left;
        logic [W-1:0] hd;
        logic [1:0]   hs;
        logic [1:0]   es;
        logic [W-1:0] ed;
        n = exp_src_q.size();
        got = 0;
        cyc = 0;
        left = stall_n;
        hd = '0;
        hs = '0;
        while (got < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > n + stall_n + 10) begin
                check({name, "/timeout"}, 32'(got), 32'(n));
                break;
            end
            if (!out_valid) begin
                check({name, "/bubble"}, 32'(out_valid), 32'd1);
                continue;
            end
            if (got == stall_at && left > 0) begin
                out_ready = 1'b0;
                if (left == stall_n) begin
                    hd = out_data;
                    hs = out_src;
                end else begin
                    check({name, "/hold_data"}, 32'(out_data), 32'(hd));
                    check({name, "/hold_src"},  32'(out_src),  32'(hs));
                end
                #1;
                check({name, "/stall_rd_en"}, 32'(req_rd_en), 32'd0);
                left--;
                continue;
            end
            out_ready = 1'b1;
            es = exp_src_q.pop_front();
            ed = exp_q.pop_front();
            check({name, "/src"},  32'(out_src),  32'(es));
            check({name, "/data"}, 32'(out_data), 32'(ed));
            got++;
        end
        out_ready = 1'b1;
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        #1;
        check({name, "/end_valid"}, 32'(out_valid), 32'd0);
        check({name, "/end_busy"},  32'(busy),      32'd0);
        check({name, "/end_rd_en"}, 32'(req_rd_en), 32'd0);
    endtask

    typedef struct {
        string name;
        int    cnt [NR];
        string order;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_cnt [NR];
        int rs_cnt [NR];

        vecs[0] = '{name: "rr_all",    cnt: '{6, 6, 6, 6}, order: "000011112222333300112233"};
        vecs[1] = '{name: "early_rot", cnt: '{0, 2, 0, 5}, order: "1133333"};
        vecs[2] = '{name: "single",    cnt: '{1, 0, 0, 0}, order: "0"};
        vecs[3] = '{name: "skip_gaps", cnt: '{3, 0, 3, 0}, order: "000222"};
        vecs[4] = '{name: "wrap_back", cnt: '{5, 1, 0, 0}, order: "000010"};
        vecs[5] = '{name: "lone_last", cnt: '{0, 0, 0, 9}, order: "333333333"};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            exp_src_q.delete();
            exp_q.delete();
            expect_seq(vecs[v].order);
            reset_and_load(vecs[v].name, vecs[v].cnt);
            check({vecs[v].name, "/first_rd_en"}, 32'(req_rd_en),
                  32'd1 << (int'(vecs[v].order.getc(0)) - 48));
            drain(vecs[v].name, -1, 0);
            idle_check(vecs[v].name);
        end

        // Stall while fifo 0 is mid-burst: burst count must not advance.
        bp_cnt = '{5, 2, 0, 0};
        exp_src_q.delete();
        exp_q.delete();
        expect_seq("0000110");
        reset_and_load("backpressure", bp_cnt);
        drain("backpressure", 1, 5);
        idle_check("backpressure");

        // Asynchronous reset between edges with an entry held in the output register.
        rs_cnt = '{0, 0, 6, 0};
        exp_src_q.delete();
        exp_q.delete();
        expect_seq("22");
        reset_and_load("mid_reset", rs_cnt);
        check("mid_reset/first_rd_en", 32'(req_rd_en), 32'h4);
        drain("mid_reset", -1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset/clr_valid", 32'(out_valid), 32'd0);
        check("mid_reset/clr_data",  32'(out_data),  32'd0);
        check("mid_reset/clr_src",   32'(out_src),   32'd0);
        check("mid_reset/clr_busy",  32'(busy),      32'd0);
        check("mid_reset/clr_rd_en", 32'(req_rd_en), 32'd0);
        load(0, 1);
        exp_src_q.delete();
        exp_q.delete();
        exp_src_q.push_back(2'd0); exp_q.push_back(8'd0);
        for (int k = 2; k < 6; k++) begin
            exp_src_q.push_back(2'd2);
            exp_q.push_back(W'(128 + k));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_reset/restart_rd_en", 32'(req_rd_en), 32'h1);
        drain("mid_reset_after", -1, 0);
        idle_check("mid_reset_after");

`ifdef FIFO_RR_ARBITER_STATS_EN
        begin
            int cyc;
            logic [NR*16-1:0] g;
            @(negedge clk);
            rst_n = 1'b0;
            for (int f = 0; f < NR; f++) tail[f] = head[f];
            tail[2] = head[2] + 70000;
            @(negedge clk);
            rst_n = 1'b1;
            cyc = 0;
            while (head[2] != tail[2] && cyc < 72000) begin
                @(negedge clk);
                cyc++;
            end
            check("stats/drained", 32'(tail[2] - head[2]), 32'd0);
            repeat (2) @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                g = grant_cnt >> (i * 16);
                check("stats/grant_cnt", 32'(g[15:0]), (i == 2) ? 32'hFFFF : 32'd0);
            end
        end
`endif

        repeat (2) @(negedge clk);
        check("rd_en_legal", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
Round-robin read-side scheduler that shares one downstream consumer between NUM_REQ fifo instances, e.g. per-axon spike queues feeding the single neuron-update datapath. Each fifo's rd_en is driven by this block. The fifo's combinational read data is captured in the same cycle as the pop. Results are presented on a registered valid/ready output stage. A grant holds for up to BURST_LEN consecutive pops before rotating.

Parameters:
NUM_REQ, 4, number of fifo requesters (>=2)
WIDTH, 8, data width of each fifo and of out_data
BURST_LEN, 4, maximum pops per grant before forced rotation (>=1)

Ports:
clk  input  1  local clock; all state on posedge
rst_n  input  1  asynchronous active-low reset
req_empty  input  NUM_REQ  per-fifo empty flags; bit i = fifo i
req_data  input  NUM_REQ*WIDTH  per-fifo out; slice i = [i*WIDTH +: WIDTH]; valid only in a cycle where req_rd_en[i]=1
req_rd_en  output  NUM_REQ  per-fifo read enable; one-hot or zero
out_valid  output  1  out_data/out_src hold a popped entry
out_ready  input  1  consumer accepts the entry this cycle
out_data  output  WIDTH  popped entry
out_src  output  $clog2(NUM_REQ)  index of the source fifo
busy  output  1  state != ARB_IDLE or out_valid

Behaviour:
- Reset (async, rst_n=0): state=ARB_IDLE, ptr=0, cur=0, burst_cnt=0, out_valid=0, out_data=0, out_src=0. req_rd_en is forced 0 while rst_n=0.
- Reset mid-operation: any entry held in the output register is dropped. Fifo contents are untouched.
- can_pop = !out_valid || out_ready. This gives full throughput: one entry per cycle with no bubble when the consumer is always ready.
- Pop: req_rd_en[g]=1 only if can_pop and req_empty[g]=0. At the same posedge: out_data<=req_data slice g, out_src<=g, out_valid<=1.
- Latency: pop cycle to out_valid = 1 cycle.
- If out_valid && out_ready and no pop occurs, out_valid<=0.
- Never assert rd_en to an empty fifo. Never assert more than one rd_en in a cycle.
- States:
  - ARB_IDLE: winner = first non-empty index searching ptr, ptr+1, ... (mod NUM_REQ).
    - If a winner exists and can_pop: pop winner, cur<=winner, burst_cnt<=1, go ARB_SERVE.
    - Otherwise stay in ARB_IDLE.
  - ARB_SERVE: rotation is due when burst_cnt==BURST_LEN or req_empty[cur]=1.
    - Not due: pop cur when can_pop, burst_cnt++. If !can_pop, hold cur and burst_cnt; no pop.
    - Due: ptr<=cur+1 (mod). Search from cur+1 in the same cycle.
      - Winner found and can_pop: pop it, cur<=winner, burst_cnt<=1 (no bubble cycle).
      - Winner found and !can_pop: go ARB_IDLE.
      - No non-empty fifo: go ARB_IDLE.
    - With a single non-empty requester, the search wraps back to cur and re-grants it.
- burst_cnt width: $clog2(BURST_LEN+1). It never exceeds BURST_LEN.
- ptr/cur wrap: NUM_REQ-1 -> 0, including non-power-of-two NUM_REQ.
- req_empty is sampled combinationally each cycle. A fifo filling while not granted waits for its round-robin turn; no starvation.
- Bound: a non-empty fifo is served within (NUM_REQ-1)*BURST_LEN pops.

Optional Feature:
Macro FIFO_RR_ARBITER_STATS_EN.
- Defined: adds output grant_cnt, width NUM_REQ*16. Slice i is a 16-bit saturating count of pops from fifo i. It resets to 0 on rst_n and holds at 16'hFFFF.
- Not defined: port and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_SERVE}
  - localparam STAT_W=16
  - function for the mod-NUM_REQ increment
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req mask (~req_empty), start index.
  - Outputs: any, winner index.
  - Instantiated twice: IDLE search from ptr, rotation search from cur+1.
- Top holds the FSM, counters and output register.

Test Plan:
- Reset: rst_n=0 with all fifos non-empty -> req_rd_en=0, out_valid=0, out_data=0. Release -> first pop from fifo 0 next cycle.
- Round-robin, BURST_LEN=4, fifos 0-3 each hold 6 entries, out_ready=1 -> out_src sequence 0,0,0,0,1,1,1,1,2,... with no idle cycles until all 24 entries are drained.
- Early rotation: fifo 1 holds 2 entries, fifo 3 holds 5, others empty -> out_src 1,1,3,3,3,3,3. Fifo 3's fifth entry is re-granted via wrap. No rd_en to an empty fifo.
- Back-pressure: out_ready=0 for 5 cycles while out_valid=1 -> out_data and out_src stable, req_rd_en=0, burst_cnt frozen. Resume -> order is preserved and no entry is lost or duplicated.
- Async reset mid-burst: assert rst_n low between clock edges during ARB_SERVE with out_valid=1 -> outputs clear immediately. After release, arbitration restarts at fifo 0.
- With FIFO_RR_ARBITER_STATS_EN: 70000 pops from fifo 2 -> grant_cnt slice 2 = 16'hFFFF; other slices = 0.
